// File: rtl/rpg_dump.sv
// ============================================================================
// rpg_dump : memory readback engine, streams words as UART 8N1 plus XOR checksum
// Optional: RPG_DUMP_HEADER_EN prepends a 4-byte header (0xA5, count LE).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rpg_dump #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [31:0]       mem_data,
  input  logic              mem_ok,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        xorc
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]     C_TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] C_ONE        = ADDR_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;
`ifdef RPG_DUMP_HEADER_EN
  localparam logic [2:0] ST_HDR   = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        xorc_q, xorc_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_read_q, mem_read_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        bit_q, bit_d;

  logic       w_sending;
  logic       w_bit_end;
  logic       w_frame_start;
  logic       w_frame_end;
  logic [7:0] w_byte;
  logic [2:0] w_bit_idx;

  // Every state that owns the line shares one bit timer / bit counter.
`ifdef RPG_DUMP_HEADER_EN
  assign w_sending = (state_q == ST_SEND) || (state_q == ST_CHK) || (state_q == ST_HDR);
`else
  assign w_sending = (state_q == ST_SEND) || (state_q == ST_CHK);
`endif
  assign w_bit_end     = (timer_q == C_TIMER_LAST);
  assign w_frame_start = (timer_q == '0) && (bit_q == 4'd0);
  assign w_frame_end   = w_bit_end && (bit_q == 4'd9);
  assign w_bit_idx     = 3'(bit_q - 4'd1);

  always_comb begin
    w_byte = xorc_q;
    case (state_q)
      ST_SEND: w_byte = data_q[{idx_q, 3'b000} +: 8];
`ifdef RPG_DUMP_HEADER_EN
      ST_HDR: begin
        case (idx_q)
          2'd0:    w_byte = 8'hA5;
          2'd1:    w_byte = remain_q[7:0];
          2'd2:    w_byte = remain_q[15:8];
          default: w_byte = {1'b0, remain_q[22:16]};
        endcase
      end
`endif
      default: w_byte = xorc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      data_q     <= '0;
      idx_q      <= 2'd0;
      xorc_q     <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_read_q <= 1'b0;
      timer_q    <= '0;
      bit_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      xorc_q     <= xorc_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_read_q <= mem_read_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef RPG_DUMP_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = (count != '0) ? ST_FETCH : ST_CHK;
`endif
        end
      end
`ifdef RPG_DUMP_HEADER_EN
      ST_HDR:   if (w_frame_end && idx_q == 2'd3)
                  state_d = (remain_q != '0) ? ST_FETCH : ST_CHK;
`endif
      ST_FETCH: if (mem_read_q && mem_ok) state_d = ST_SEND;
      ST_SEND:  if (w_frame_end && idx_q == 2'd3)
                  state_d = (remain_q == C_ONE) ? ST_CHK : ST_FETCH;
      ST_CHK:   if (w_frame_end) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    remain_d   = remain_q;
    data_d     = data_q;
    idx_d      = idx_q;
    xorc_d     = xorc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_read_d = mem_read_q;
    timer_d    = '0;
    bit_d      = 4'd0;
    tx_d       = 1'b1;

    if (w_sending) begin
      case (bit_q)
        4'd0:    tx_d = 1'b0;
        4'd9:    tx_d = 1'b1;
        default: tx_d = w_byte[w_bit_idx];
      endcase
      if (w_bit_end) begin
        if (bit_q == 4'd9) begin
          idx_d = idx_q + 2'd1;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        timer_d = timer_q + TW'(1);
        bit_d   = bit_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = count;
          xorc_d   = 8'h00;
          busy_d   = 1'b1;
          idx_d    = 2'd0;
`ifdef RPG_DUMP_HEADER_EN
          mem_read_d = 1'b0;
`else
          mem_read_d = (count != '0);
`endif
        end
      end
`ifdef RPG_DUMP_HEADER_EN
      ST_HDR: begin
        if (w_frame_end && idx_q == 2'd3) mem_read_d = (remain_q != '0);
      end
`endif
      ST_FETCH: begin
        if (mem_read_q && mem_ok) begin
          data_d     = mem_data;
          mem_read_d = 1'b0;
          idx_d      = 2'd0;
        end
      end
      ST_SEND: begin
        if (w_frame_start) xorc_d = xorc_q ^ w_byte;
        if (w_frame_end && idx_q == 2'd3) begin
          remain_d   = remain_q - C_ONE;
          addr_d     = addr_q + C_ONE;
          mem_read_d = (remain_q != C_ONE);
        end
      end
      ST_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_read = mem_read_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign xorc     = xorc_q;

endmodule

`default_nettype wire
